// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - fetch controller control/ROM/IF-ID signal bundle
// Purpose: groups the pipeline-control inputs, the instruction ROM bus and the
//          IF/ID register outputs of imem_fetch_ctrl into one interface.
// Signals:
//   i_stall, i_redirect, i_redirect_pc   pipeline control into the fetch stage
//   i_imem_data / o_imem_addr            combinational instruction ROM bus
//   o_instr, o_pc4, o_valid              IF/ID pipeline register
//   o_halted, o_misalign                 status
//   o_fetch_cnt, o_bubble_cnt            perf counters (IMEM_FETCH_PERF_EN only)
// Modports: master = fetch controller, slave = surrounding pipeline / ROM.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_stall;
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;
    logic [DATA_WIDTH-1:0] i_imem_data;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [DATA_WIDTH-1:0] o_instr;
    logic [ADDR_WIDTH-1:0] o_pc4;
    logic                  o_valid;
    logic                  o_halted;
    logic                  o_misalign;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0]           o_fetch_cnt;
    logic [31:0]           o_bubble_cnt;
`endif

    modport master (
`ifdef IMEM_FETCH_PERF_EN
        output o_fetch_cnt,
        output o_bubble_cnt,
`endif
        input  i_stall,
        input  i_redirect,
        input  i_redirect_pc,
        input  i_imem_data,
        output o_imem_addr,
        output o_instr,
        output o_pc4,
        output o_valid,
        output o_halted,
        output o_misalign
    );

    modport slave (
`ifdef IMEM_FETCH_PERF_EN
        input  o_fetch_cnt,
        input  o_bubble_cnt,
`endif
        output i_stall,
        output i_redirect,
        output i_redirect_pc,
        output i_imem_data,
        input  o_imem_addr,
        input  o_instr,
        input  o_pc4,
        input  o_valid,
        input  o_halted,
        input  o_misalign
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - MIPS fetch-stage PC sequencer and IF/ID register
// Purpose: owns the PC, addresses the combinational instruction ROM, loads the
//          IF/ID register and handles stall, redirect/flush, out-of-range halt
//          and misaligned redirect detection. FSM states: BOOT, RUN, HALT.
// Ports:
//   i_clk  clock, all state changes on the rising edge
//   i_rst  synchronous active-high reset
//   bus    imem_fetch_ctrl_if.master (control in, ROM bus, IF/ID out, status)
// Optional: define IMEM_FETCH_PERF_EN to add saturating fetch/bubble counters.
module imem_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ROM_WORDS  = 256,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
    input logic              i_clk,
    input logic              i_rst,
    imem_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    // One extra bit so 4*ROM_WORDS never aliases to zero at full address width.
    localparam logic [ADDR_WIDTH:0] PC_LIMIT = (ADDR_WIDTH+1)'(ROM_WORDS) << 2;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [ADDR_WIDTH-1:0] pc4_q, pc4_nxt;
    logic [DATA_WIDTH-1:0] instr_q, instr_nxt;
    logic                  valid_q, valid_nxt;
    logic                  misalign_q, misalign_nxt;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic                  pc_oor;
    logic                  tgt_oor;
    logic                  tgt_misaligned;

    assign pc_plus4       = pc + ADDR_WIDTH'(4);
    assign redirect_tgt   = {bus.i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign pc_oor         = {1'b0, pc} >= PC_LIMIT;
    assign tgt_oor        = {1'b0, redirect_tgt} >= PC_LIMIT;
    assign tgt_misaligned = |bus.i_redirect_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            pc4_q      <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc4_q      <= pc4_nxt;
            instr_q    <= instr_nxt;
            valid_q    <= valid_nxt;
            misalign_q <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pc4_nxt      = pc4_q;
        instr_nxt    = instr_q;
        valid_nxt    = valid_q;
        misalign_nxt = misalign_q;
        case (state)
            S_BOOT: begin
                state_nxt = S_RUN;
                valid_nxt = 1'b0;
            end
            S_RUN: begin
                if (bus.i_redirect) begin
                    // Redirect beats stall and halt: the in-flight fetch is wrong-path.
                    pc_nxt       = redirect_tgt;
                    valid_nxt    = 1'b0;
                    instr_nxt    = NOP_INSTR;
                    misalign_nxt = misalign_q | tgt_misaligned;
                end else if (bus.i_stall) begin
                    // hold everything
                end else if (pc_oor) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = S_HALT;
                end else begin
                    instr_nxt = bus.i_imem_data;
                    pc4_nxt   = pc_plus4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                end
            end
            S_HALT: begin
                valid_nxt = 1'b0;
                // Only an in-range redirect can restart fetch without a reset.
                if (bus.i_redirect && !tgt_oor) begin
                    pc_nxt       = redirect_tgt;
                    instr_nxt    = NOP_INSTR;
                    misalign_nxt = misalign_q | tgt_misaligned;
                    state_nxt    = S_RUN;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    assign bus.o_imem_addr = {2'b00, pc[ADDR_WIDTH-1:2]};
    assign bus.o_instr     = instr_q;
    assign bus.o_pc4       = pc4_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_halted    = (state == S_HALT);
    assign bus.o_misalign  = misalign_q;

`ifdef IMEM_FETCH_PERF_EN
    logic        fetch_evt;
    logic        bubble_evt;
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    assign fetch_evt  = (state == S_RUN) && !bus.i_redirect && !bus.i_stall && !pc_oor;
    assign bubble_evt = (state == S_RUN) && (bus.i_redirect || bus.i_stall);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (fetch_evt && fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bubble_evt && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign bus.o_fetch_cnt  = fetch_cnt;
    assign bus.o_bubble_cnt = bubble_cnt;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    imem_fetch_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    imem_fetch_ctrl #(.ROM_WORDS(256)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.master));
    imem_fetch_ctrl #(.ROM_WORDS(8))   dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.master));

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return {16'hC0DE, idx[15:0]};
    endfunction

    assign ifa.i_imem_data = rom_word(ifa.o_imem_addr);
    assign ifb.i_imem_data = rom_word(ifb.o_imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ifa.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ifa.o_valid); end
        checks++; if (ifa.o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", ifa.o_instr); end
        checks++; if (ifa.o_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", ifa.o_pc4); end
        checks++; if (ifa.o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", ifa.o_imem_addr); end
        checks++; if (ifa.o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", ifa.o_halted); end
        checks++; if (ifa.o_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b want 0", ifa.o_misalign); end
    endtask

    task automatic test_sequence();
        step();
        checks++; if (ifa.o_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %0b want 0", ifa.o_valid); end
        checks++; if (ifa.o_imem_addr !== 32'h0) begin errors++; $display("FAIL boot_addr: got %h want 0", ifa.o_imem_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (ifa.o_instr !== rom_word(k)) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", k, ifa.o_instr, rom_word(k)); end
            checks++; if (ifa.o_pc4 !== 32'(4*(k+1))) begin errors++; $display("FAIL seq_pc4[%0d]: got %h want %h", k, ifa.o_pc4, 4*(k+1)); end
            checks++; if (ifa.o_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %0b want 1", k, ifa.o_valid); end
            checks++; if (ifa.o_imem_addr !== 32'(k+1)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", k, ifa.o_imem_addr, k+1); end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        step();
        step();
        step();
        ifa.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (ifa.o_instr !== rom_word(1)) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", k, ifa.o_instr, rom_word(1)); end
            checks++; if (ifa.o_pc4 !== 32'h8) begin errors++; $display("FAIL stall_pc4[%0d]: got %h want 8", k, ifa.o_pc4); end
            checks++; if (ifa.o_imem_addr !== 32'h2) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 2", k, ifa.o_imem_addr); end
            checks++; if (ifa.o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", k, ifa.o_valid); end
        end
        ifa.i_stall = 1'b0;
        step();
        checks++; if (ifa.o_instr !== rom_word(2)) begin errors++; $display("FAIL unstall_instr: got %h want %h", ifa.o_instr, rom_word(2)); end
        checks++; if (ifa.o_pc4 !== 32'hC) begin errors++; $display("FAIL unstall_pc4: got %h want c", ifa.o_pc4); end
    endtask

    task automatic test_redirect_stall();
        ifa.i_redirect    = 1'b1;
        ifa.i_redirect_pc = 32'h40;
        ifa.i_stall       = 1'b1;
        step();
        ifa.i_redirect = 1'b0;
        ifa.i_stall    = 1'b0;
        checks++; if (ifa.o_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %0b want 0", ifa.o_valid); end
        checks++; if (ifa.o_instr !== 32'h0) begin errors++; $display("FAIL redir_flush: got %h want 0", ifa.o_instr); end
        checks++; if (ifa.o_imem_addr !== 32'd16) begin errors++; $display("FAIL redir_addr: got %h want 10", ifa.o_imem_addr); end
        step();
        checks++; if (ifa.o_instr !== rom_word(16)) begin errors++; $display("FAIL redir_instr: got %h want %h", ifa.o_instr, rom_word(16)); end
        checks++; if (ifa.o_pc4 !== 32'h44) begin errors++; $display("FAIL redir_pc4: got %h want 44", ifa.o_pc4); end
        checks++; if (ifa.o_misalign !== 1'b0) begin errors++; $display("FAIL redir_misalign: got %0b want 0", ifa.o_misalign); end
    endtask

    task automatic test_misalign();
        ifa.i_redirect    = 1'b1;
        ifa.i_redirect_pc = 32'h42;
        step();
        ifa.i_redirect = 1'b0;
        checks++; if (ifa.o_imem_addr !== 32'd16) begin errors++; $display("FAIL mis_addr: got %h want 10", ifa.o_imem_addr); end
        checks++; if (ifa.o_misalign !== 1'b1) begin errors++; $display("FAIL mis_set: got %0b want 1", ifa.o_misalign); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (ifa.o_misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky[%0d]: got %0b want 1", k, ifa.o_misalign); end
        end
        checks++; if (ifa.o_instr !== rom_word(18)) begin errors++; $display("FAIL mis_instr: got %h want %h", ifa.o_instr, rom_word(18)); end
    endtask

    task automatic test_perf_counters();
`ifdef IMEM_FETCH_PERF_EN
        apply_reset();
        step();
        step();
        step();
        ifa.i_stall = 1'b1;
        step();
        ifa.i_stall       = 1'b0;
        ifa.i_redirect    = 1'b1;
        ifa.i_redirect_pc = 32'h0;
        step();
        ifa.i_redirect = 1'b0;
        step();
        checks++; if (ifa.o_fetch_cnt !== 32'd3) begin errors++; $display("FAIL perf_fetch: got %0d want 3", ifa.o_fetch_cnt); end
        checks++; if (ifa.o_bubble_cnt !== 32'd2) begin errors++; $display("FAIL perf_bubble: got %0d want 2", ifa.o_bubble_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        ifa.i_redirect    = 1'b1;
        ifa.i_redirect_pc = 32'h16;
        step();
        ifa.i_redirect = 1'b0;
        step();
        step();
        checks++; if (ifa.o_imem_addr !== 32'd7) begin errors++; $display("FAIL mid_pre_addr: got %h want 7", ifa.o_imem_addr); end
        checks++; if (ifa.o_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b want 1", ifa.o_valid); end
        checks++; if (ifa.o_misalign !== 1'b1) begin errors++; $display("FAIL mid_pre_misalign: got %0b want 1", ifa.o_misalign); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (ifa.o_imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 0", ifa.o_imem_addr); end
        checks++; if (ifa.o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", ifa.o_valid); end
        checks++; if (ifa.o_misalign !== 1'b0) begin errors++; $display("FAIL mid_misalign: got %0b want 0", ifa.o_misalign); end
        checks++; if (ifa.o_pc4 !== 32'h0) begin errors++; $display("FAIL mid_pc4: got %h want 0", ifa.o_pc4); end
`ifdef IMEM_FETCH_PERF_EN
        checks++; if (ifa.o_fetch_cnt !== 32'd0) begin errors++; $display("FAIL mid_fetch_cnt: got %0d want 0", ifa.o_fetch_cnt); end
        checks++; if (ifa.o_bubble_cnt !== 32'd0) begin errors++; $display("FAIL mid_bubble_cnt: got %0d want 0", ifa.o_bubble_cnt); end
`endif
    endtask

    task automatic test_halt();
        apply_reset();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            checks++; if (ifb.o_instr !== rom_word(k)) begin errors++; $display("FAIL halt_seq_instr[%0d]: got %h want %h", k, ifb.o_instr, rom_word(k)); end
        end
        checks++; if (ifb.o_halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b want 0", ifb.o_halted); end
        ifb.i_stall = 1'b1;
        step();
        ifb.i_stall = 1'b0;
        checks++; if (ifb.o_halted !== 1'b0) begin errors++; $display("FAIL halt_stall_wins: got %0b want 0", ifb.o_halted); end
        checks++; if (ifb.o_instr !== rom_word(7)) begin errors++; $display("FAIL halt_stall_instr: got %h want %h", ifb.o_instr, rom_word(7)); end
        step();
        checks++; if (ifb.o_halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %0b want 1", ifb.o_halted); end
        checks++; if (ifb.o_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %0b want 0", ifb.o_valid); end
        checks++; if (ifb.o_imem_addr !== 32'd8) begin errors++; $display("FAIL halt_addr: got %h want 8", ifb.o_imem_addr); end
        ifb.i_redirect    = 1'b1;
        ifb.i_redirect_pc = 32'h8;
        step();
        ifb.i_redirect = 1'b0;
        checks++; if (ifb.o_halted !== 1'b0) begin errors++; $display("FAIL halt_resume: got %0b want 0", ifb.o_halted); end
        checks++; if (ifb.o_imem_addr !== 32'd2) begin errors++; $display("FAIL halt_resume_addr: got %h want 2", ifb.o_imem_addr); end
        step();
        checks++; if (ifb.o_instr !== rom_word(2)) begin errors++; $display("FAIL halt_resume_instr: got %h want %h", ifb.o_instr, rom_word(2)); end
        checks++; if (ifb.o_pc4 !== 32'hC) begin errors++; $display("FAIL halt_resume_pc4: got %h want c", ifb.o_pc4); end
        for (int k = 3; k < 8; k++) step();
        step();
        checks++; if (ifb.o_halted !== 1'b1) begin errors++; $display("FAIL halt_reenter: got %0b want 1", ifb.o_halted); end
        ifb.i_redirect    = 1'b1;
        ifb.i_redirect_pc = 32'h100;
        step();
        ifb.i_redirect = 1'b0;
        checks++; if (ifb.o_halted !== 1'b1) begin errors++; $display("FAIL halt_oor_redirect: got %0b want 1", ifb.o_halted); end
        checks++; if (ifb.o_imem_addr !== 32'd8) begin errors++; $display("FAIL halt_oor_addr: got %h want 8", ifb.o_imem_addr); end
        step();
        checks++; if (ifb.o_valid !== 1'b0) begin errors++; $display("FAIL halt_oor_valid: got %0b want 0", ifb.o_valid); end
    endtask

    initial begin
        ifa.i_stall       = 1'b0;
        ifa.i_redirect    = 1'b0;
        ifa.i_redirect_pc = 32'h0;
        ifb.i_stall       = 1'b0;
        ifb.i_redirect    = 1'b0;
        ifb.i_redirect_pc = 32'h0;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_perf_counters();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
